// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues in-order word fetches, buffers {pc, instr} in a DEPTH-entry FIFO, and hands them to decode on valid/ready.
// Latency: response -> dec_valid one cycle later. Backpressure: decode stalls fill the FIFO, and occupancy+outstanding <= DEPTH throttles issue.
// Optional ILLEGAL_OPCODE_CHECK_EN: flags unsupported head opcodes on dec_illegal.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        dec_illegal
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    state_q;
    logic [31:0]   pc_q;
    logic [31:0]   rsp_pc_q;
    logic [AW:0]   outstanding_q;
    logic [AW:0]   drop_cnt_q;
    logic [AW:0]   count_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];

    logic          empty;
    logic          full;
    logic [AW+1:0] inflight;
    logic          fire;
    logic          rsp_ok;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [AW:0]   redir_left;
    logic [AW:0]   drop_next;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_W);
    assign inflight = {1'b0, count_q} + {1'b0, outstanding_q};

    assign imem_req_valid = (state_q == S_RUN) && !redirect_valid && (inflight < {1'b0, DEPTH_W});
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding cannot belong to us (e.g. straddling reset); ignore it.
    assign rsp_ok   = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = rsp_ok && (drop_cnt_q != '0);
    assign push     = rsp_ok && (drop_cnt_q == '0) && !redirect_valid;

    assign dec_valid = !empty && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? fifo_instr[rd_ptr_q] : NOP;
    assign dec_pc    = empty ? rsp_pc_q : fifo_pc[rd_ptr_q];

    // The response arriving in the redirect cycle is consumed there, so it does not need dropping later.
    assign redir_left = outstanding_q - (AW+1)'(rsp_ok);
    assign drop_next  = drop_cnt_q - (AW+1)'(rsp_drop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else if (redirect_valid) begin
            pc_q          <= redirect_pc & ~32'h3;
            rsp_pc_q      <= redirect_pc & ~32'h3;
            outstanding_q <= redir_left;
            drop_cnt_q    <= redir_left;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            state_q       <= (redir_left != '0) ? S_FLUSH : S_RUN;
        end else begin
            if (fire) begin
                pc_q <= pc_q + 32'd4;
            end
            outstanding_q <= outstanding_q + (AW+1)'(fire) - (AW+1)'(rsp_ok);
            drop_cnt_q    <= drop_next;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rsp_pc_q <= rsp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            case (state_q)
                S_IDLE:  state_q <= S_RUN;
                S_FLUSH: state_q <= (drop_next == '0) ? S_RUN : S_FLUSH;
                default: state_q <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rsp_data;
            fifo_pc[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    // Credits should make an overflowing push impossible.
    always_ff @(posedge clk) begin
        assert (!(reset && push && full))
            else $error("instr_fetch_buffer: push into full FIFO");
    end

`ifdef ILLEGAL_OPCODE_CHECK_EN
    logic opc_ok;

    always_comb begin
        opc_ok = 1'b0;
        case (dec_instr[6:0])
            7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b1101111,
            7'b0110011, 7'b1100111, 7'b0010111: opc_ok = 1'b1;
            default:                            opc_ok = 1'b0;
        endcase
    end

    assign dec_illegal = dec_valid && !opc_ok;
`else
    assign dec_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a small in-order instruction memory model.
module tb_instr_fetch_buffer;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        dec_illegal;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;

    logic [31:0] pend [$];
    bit          mem_en;
    bit          ovr;
    logic [31:0] ovr_data;

    instr_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .dec_illegal    (dec_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[26:2], 7'b0010011};
    endfunction

    // One clock: sample handshakes, take the edge, then advance the memory model.
    task automatic cycle();
        logic        fire;
        logic        taken;
        logic        rst_seen;
        logic [31:0] a;
        #1;
        fire     = imem_req_valid && imem_req_ready;
        a        = imem_req_addr;
        taken    = imem_rsp_valid;
        rst_seen = !reset;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (rst_seen) begin
            pend.delete();
        end else begin
            if (taken && pend.size() > 0) void'(pend.pop_front());
            if (fire) begin
                pend.push_back(a);
                fire_cnt++;
            end
        end
        if (mem_en && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ovr ? ovr_data : instr_of(pend[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        mem_en         = 1'b1;
        ovr            = 1'b0;
        ovr_data       = 32'h0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        mem_en         = 1'b1;
        ovr            = 1'b0;
        ovr_data       = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        cycle();
        cycle();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 00000000", imem_req_addr); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
        checks++; if (dec_instr !== 32'h13) begin errors++; $display("FAIL reset_dec_instr got %h want 00000013", dec_instr); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got %h want 00000000", dec_pc); end
        checks++; if (dec_illegal !== 1'b0) begin errors++; $display("FAIL reset_dec_illegal got %b want 0", dec_illegal); end
    endtask

    task automatic test_fetch();
        do_reset();
        dec_ready = 1'b1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL fetch_first_req got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        cycle();
        checks++; if (imem_req_addr !== 32'h4 || dec_valid !== 1'b0) begin errors++; $display("FAIL fetch_c1 got addr %h vld %b want 00000004/0", imem_req_addr, dec_valid); end
        cycle();
        checks++; if (imem_req_addr !== 32'h8) begin errors++; $display("FAIL fetch_c2_addr got %h want 00000008", imem_req_addr); end
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== instr_of(32'h0)) begin errors++; $display("FAIL fetch_first_dec got %b/%h/%h want 1/00000000/%h", dec_valid, dec_pc, dec_instr, instr_of(32'h0)); end
        cycle();
        checks++; if (imem_req_addr !== 32'hC || dec_pc !== 32'h4 || dec_valid !== 1'b1) begin errors++; $display("FAIL fetch_c3 got addr %h pc %h vld %b want 0000000c/00000004/1", imem_req_addr, dec_pc, dec_valid); end
    endtask

    task automatic test_backpressure();
        int start;
        do_reset();
        start = fire_cnt;
        for (int i = 0; i < 10; i++) cycle();
        checks++; if (fire_cnt - start !== 4) begin errors++; $display("FAIL bp_fire_count got %0d want 4", fire_cnt - start); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled got %b want 0", imem_req_valid); end
        dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(i * 4)) begin errors++; $display("FAIL bp_pop_%0d got %b/%h want 1/%h", i, dec_valid, dec_pc, 32'(i * 4)); end
            cycle();
            if (i == 0) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_resume got %b/%h want 1/00000010", imem_req_valid, imem_req_addr); end
            end
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_redirect_flush();
        do_reset();
        cycle();
        mem_en = 1'b0;
        cycle();
        cycle();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin errors++; $display("FAIL rf_pre got %b/%h want 1/00000000", dec_valid, dec_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL rf_redirect_cycle got req %b dec %b want 0/0", imem_req_valid, dec_valid); end
        cycle();
        checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100 || dec_valid !== 1'b0) begin errors++; $display("FAIL rf_flush got %b/%h/%b want 0/00000100/0", imem_req_valid, imem_req_addr, dec_valid); end
        mem_en = 1'b1;
        cycle();
        cycle();
        checks++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL rf_still_flush got req %b dec %b want 0/0", imem_req_valid, dec_valid); end
        cycle();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || dec_valid !== 1'b0) begin errors++; $display("FAIL rf_run got %b/%h/%b want 1/00000100/0", imem_req_valid, imem_req_addr, dec_valid); end
        cycle();
        cycle();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== instr_of(32'h100)) begin errors++; $display("FAIL rf_first_dec got %b/%h/%h want 1/00000100/%h", dec_valid, dec_pc, dec_instr, instr_of(32'h100)); end
    endtask

    task automatic test_redirect_same_rsp();
        do_reset();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || dec_valid !== 1'b0) begin errors++; $display("FAIL rs_run got %b/%h/%b want 1/00000200/0", imem_req_valid, imem_req_addr, dec_valid); end
        cycle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rs_no_stale got %b want 0", dec_valid); end
        cycle();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_instr !== instr_of(32'h200)) begin errors++; $display("FAIL rs_dec got %b/%h/%h want 1/00000200/%h", dec_valid, dec_pc, dec_instr, instr_of(32'h200)); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr); end
        cycle();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        cycle();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_dec got %b/%h want 1/fffffffc", dec_valid, dec_pc); end
    endtask

    task automatic test_illegal();
        logic exp_ill;
`ifdef ILLEGAL_OPCODE_CHECK_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        do_reset();
        ovr      = 1'b1;
        ovr_data = 32'h0000_007F;
        cycle();
        ovr_data = 32'h0000_0013;
        cycle();
        checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'h7F || dec_illegal !== exp_ill) begin errors++; $display("FAIL ill_7f got %b/%h/%b want 1/0000007f/%b", dec_valid, dec_instr, dec_illegal, exp_ill); end
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'h13 || dec_illegal !== 1'b0) begin errors++; $display("FAIL ill_13 got %b/%h/%b want 1/00000013/0", dec_valid, dec_instr, dec_illegal); end
        ovr = 1'b0;
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (dec_valid !== 1'b1 || imem_req_valid !== 1'b0 || dec_pc !== 32'h0) begin errors++; $display("FAIL mr_pre got %b/%b/%h want 1/0/00000000", dec_valid, imem_req_valid, dec_pc); end
        reset = 1'b0;
        cycle();
        checks++; if (dec_valid !== 1'b0 || imem_req_addr !== 32'h0 || imem_req_valid !== 1'b0 || dec_instr !== 32'h13) begin errors++; $display("FAIL mr_reset got %b/%h/%b/%h want 0/00000000/0/00000013", dec_valid, imem_req_addr, imem_req_valid, dec_instr); end
        reset = 1'b1;
        cycle();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL mr_restart got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
        cycle();
        cycle();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== instr_of(32'h0)) begin errors++; $display("FAIL mr_dec got %b/%h/%h want 1/00000000/%h", dec_valid, dec_pc, dec_instr, instr_of(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect_flush();
        test_redirect_same_rsp();
        test_wrap();
        test_illegal();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
